// File: rtl/ex_mdu.sv
// Iterative RV64M multiply/divide unit for the EX stage (shift-add multiply, restoring divide).
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle instead of iterating.
module ex_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stall_req_o
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] acc_q, lo_q, b_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      op_q;
  logic            spec_q, neg_res_q, neg_rem_q;

  // Operand preparation for the instruction presented in IDLE
  logic            is_w, is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, spec_hit;
  logic [XLEN-1:0] a_sx, b_sx, a_ext, b_ext, a_mag, b_mag, spec_val;

  always_comb begin
    is_w     = op_i[3];
    is_div   = op_i[2];
    a_signed = is_div ? ~op_i[0] : (~is_w & ((op_i[1:0] == 2'd1) | (op_i[1:0] == 2'd2)));
    b_signed = is_div ? ~op_i[0] : (~is_w & (op_i[1:0] == 2'd1));
    a_sx     = is_w ? {{HALF{src1_i[HALF-1]}}, src1_i[HALF-1:0]} : src1_i;
    b_sx     = is_w ? {{HALF{src2_i[HALF-1]}}, src2_i[HALF-1:0]} : src2_i;
    if (is_w) begin
      a_ext = a_signed ? a_sx : {{HALF{1'b0}}, src1_i[HALF-1:0]};
      b_ext = b_signed ? b_sx : {{HALF{1'b0}}, src2_i[HALF-1:0]};
    end else begin
      a_ext = src1_i;
      b_ext = src2_i;
    end
    a_neg    = a_signed & a_ext[XLEN-1];
    b_neg    = b_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & a_signed & (a_ext == (is_w ? MIN_W : MIN_D)) & (b_ext == '1);
    spec_hit = div_zero | div_ovf;
    // Special-case results use the raw dividend, sign-extended from bit 31 for W ops
    if (div_zero) spec_val = op_i[1] ? a_sx : '1;
    else          spec_val = op_i[1] ? '0 : a_sx;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  // One iteration of shift-add multiply and restoring divide
  logic [XLEN:0]   mul_sum, div_rs;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_rs   = {acc_q, lo_q[XLEN-1]};
    div_ge   = div_rs >= {1'b0, b_q};
    div_diff = div_rs[XLEN-1:0] - b_q;
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, sel, fix_result;

  always_comb begin
    prod   = {acc_q, lo_q};
    prod_s = neg_res_q ? -prod : prod;
    quo    = neg_res_q ? -lo_q : lo_q;
    rem    = neg_rem_q ? -acc_q : acc_q;
    sel    = op_q[1] ? rem : quo;
    if (spec_q)
      fix_result = lo_q;
    else if (op_q[2])
      fix_result = op_q[3] ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
    else if (op_q[3])
      // W multiply: 32 iterations leave the product aligned at bit 32 of the 2*XLEN register
      fix_result = {{HALF{lo_q[XLEN-1]}}, lo_q[XLEN-1:HALF]};
    else if (op_q[1:0] == 2'd0)
      fix_result = prod_s[XLEN-1:0];
    else
      fix_result = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush) begin
          if (spec_hit) state_d = S_FIX;
`ifdef MDU_FAST_MUL_EN
          else if (!is_div) state_d = S_FIX;
`endif
          else state_d = S_CALC;
        end
      end
      S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    done_o      = (state_q == S_DONE);
    busy_o      = (state_q == S_CALC) || (state_q == S_FIX);
    stall_req_o = busy_o || (valid_i && (state_q == S_IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      spec_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i && !flush) begin
            op_q      <= op_i;
            spec_q    <= spec_hit;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            b_q       <= b_mag;
            cnt_q     <= is_w ? CW'(HALF) : CW'(XLEN);
            acc_q     <= '0;
            if (spec_hit)    lo_q <= spec_val;
            else if (is_div) lo_q <= is_w ? (a_mag << HALF) : a_mag;
            else             lo_q <= a_mag;
`ifdef MDU_FAST_MUL_EN
            if (!spec_hit && !is_div)
              {acc_q, lo_q} <= is_w ? (fast_prod << HALF) : fast_prod;
`endif
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (op_q[2]) begin
            acc_q <= div_ge ? div_diff : div_rs[XLEN-1:0];
            lo_q  <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            acc_q <= mul_sum[XLEN:1];
            lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
        S_FIX: begin
          if (!flush) result_q <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Iterative multiply/divide unit for the EX stage, fed by the ID/EX pipeline register outputs (rs1/rs2 operands, ALU control) alongside the single-cycle ALU.
- Implements RV64M: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
- While an operation is in flight, raises a stall request that freezes the upstream ID/EX and IF/ID registers.
- Delivers a one-cycle done pulse with the result to the EX/MEM path.

Parameters:
- XLEN, 64, datapath width (RV64).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  M-extension instruction present in EX.
- op_i  in  4  operation select.
  - bit3 = W (32-bit) variant.
  - bits2:0: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1_i  in  XLEN  rs1 operand (after forwarding).
- src2_i  in  XLEN  rs2 operand (after forwarding).
- flush  in  1  kill in-flight operation.
- result_o  out  XLEN  result; valid while done_o is high.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  operation in flight.
- stall_req_o  out  1  freeze request to upstream registers.

Behaviour:
- Reset: state IDLE; result_o, done_o, busy_o, counter, and all internal operand/accumulator registers are 0.
- States:
  - IDLE: if valid_i & ~flush, latch operands, go to CALC (or FIX for special cases or the fast multiply).
  - CALC: one bit per cycle, shift-add multiply or restoring divide. Iteration count is XLEN, or 32 for W ops. After the last iteration go to FIX.
  - FIX: sign correction and select the high/low half or quotient/remainder. W ops sign-extend bit 31 into bits 63:32. Go to DONE.
  - DONE: done_o = 1 and result_o valid for exactly one cycle, then IDLE.
- Latency, counted from the cycle valid_i is accepted to the cycle done_o is high: XLEN+2 (66) for 64-bit ops, 34 for W ops.
- Operand handling:
  - Signed ops take absolute values at latch and negate in FIX when the sign requires it.
  - MULHSU treats src1 as signed and src2 as unsigned.
  - W ops use the low 32 bits, sign- or zero-extended per op.
- Special cases (skip CALC, latency 2):
  - Divide by zero: quotient = all ones (-1 for the W variant, sign-extended); remainder = dividend.
  - Signed overflow, most-negative / -1: quotient = dividend; remainder = 0.
- busy_o = 1 in CALC and FIX.
- stall_req_o = busy_o | (valid_i & state==IDLE). It is low in DONE, so the pipeline advances on the done cycle.
- valid_i is ignored outside IDLE. Operands are never re-sampled mid-operation.
- flush, in any state: return to IDLE at the next edge, done_o stays 0, and result_o keeps its old value. A flush coincident with valid_i in IDLE causes no start. A flush in DONE still lets that cycle's done_o pulse complete.
- A back-to-back instruction re-asserting valid_i in the cycle after DONE starts normally.
- Asynchronous reset mid-operation aborts immediately to the reset values.

Optional Feature:
- MDU_FAST_MUL_EN.
- Defined: multiply ops compute the 2*XLEN product in a single cycle, IDLE→FIX, latency 2. Divide ops are unchanged.
- Undefined: all multiply ops use the iterative path, latency 66 (34 for MULW).

Test Plan:
- MUL src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD) → result_o=0xFFFF_FFFF_FFFF_FFEB.
  - done_o at cycle 66 without the macro, cycle 2 with it.
  - stall_req_o high from acceptance until the done cycle.
- DIV -20/6 → 0xFFFF_FFFF_FFFF_FFFD (-3). REM -20/6 → -2. DIVU 20/6 → 3. All at latency 66.
- DIVW src1=0x0000_0001_8000_0000, src2=-1 → signed overflow, result 0xFFFF_FFFF_8000_0000 at latency 2. REMUW 5/0 → 5. DIV 9/0 → 0xFFFF_FFFF_FFFF_FFFF.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → 1. MULH -1 × -1 → 0. MULHSU -1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- Start DIV 100/7, assert flush at cycle 10 → no done_o, IDLE next cycle. A new DIVU 100/7 then returns 14 at latency 66.
- Deassert rst_n at cycle 30 of a DIV → all outputs 0 immediately. After release, valid_i with DIVW 15/4 yields 3 at latency 34.
